// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: opcodes, states,
// ALU commands, datapath mux selects and the decoded instruction classes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_SLT = 3'd3
    } alu_op_t;

    localparam logic [1:0] PCSRC_RS     = 2'd0;
    localparam logic [1:0] PCSRC_JUMP   = 2'd1;
    localparam logic [1:0] PCSRC_BRANCH = 2'd2;

    localparam logic [1:0] REGDST_R31 = 2'd0;
    localparam logic [1:0] REGDST_RT  = 2'd1;
    localparam logic [1:0] REGDST_RD  = 2'd2;

    localparam logic [1:0] REGSRC_PC  = 2'd0;
    localparam logic [1:0] REGSRC_MEM = 2'd1;
    localparam logic [1:0] REGSRC_ALU = 2'd2;

    localparam logic BRSEL_TAKEN = 1'b0;
    localparam logic BRSEL_SEQ   = 1'b1;

    localparam logic MEMADDR_ALU = 1'b0;
    localparam logic MEMADDR_PC  = 1'b1;

    localparam logic ALUSRC_IMM = 1'b0;
    localparam logic ALUSRC_B   = 1'b1;

    typedef enum logic [3:0] {
        CLS_NONE = 4'd0,
        CLS_LW   = 4'd1,
        CLS_SW   = 4'd2,
        CLS_J    = 4'd3,
        CLS_JAL  = 4'd4,
        CLS_BNE  = 4'd5,
        CLS_ADDI = 4'd6,
        CLS_XORI = 4'd7,
        CLS_ADD  = 4'd8,
        CLS_SUB  = 4'd9,
        CLS_SLT  = 4'd10,
        CLS_JR   = 4'd11
    } instr_class_t;

    // ALU command for a class; also reused in WB so the ALU result stays stable.
    function automatic alu_op_t alu_cmd_of(input instr_class_t cls);
        case (cls)
            CLS_BNE, CLS_SUB: return ALU_SUB;
            CLS_XORI:         return ALU_XOR;
            CLS_SLT:          return ALU_SLT;
            default:          return ALU_ADD;
        endcase
    endfunction

    function automatic logic alu_src_of(input instr_class_t cls);
        case (cls)
            CLS_BNE, CLS_ADD, CLS_SUB, CLS_SLT: return ALUSRC_B;
            default:                            return ALUSRC_IMM;
        endcase
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct classifier; anything outside the supported subset
// comes out as CLS_NONE with legal low.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t cls,
    output logic         legal
);

    always_comb begin
        cls = CLS_NONE;
        case (opcode)
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            OP_BNE:  cls = CLS_BNE;
            OP_ADDI: cls = CLS_ADDI;
            OP_XORI: cls = CLS_XORI;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cls = CLS_ADD;
                    FN_SUB:  cls = CLS_SUB;
                    FN_SLT:  cls = CLS_SLT;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_NONE;
                endcase
            end
            default: cls = CLS_NONE;
        endcase
    end

    assign legal = (cls != CLS_NONE);

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the single-memory multi-cycle MIPS-subset datapath.
// Optional performance counters are built in when MC_PERF_CNT_EN is defined.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_we,
    output logic       br_sel,
    output logic [1:0] pc_src,
    output logic       mem_addr_sel,
    output logic       mem_we,
    output logic       ir_sel,
    output logic [1:0] reg_dst,
    output logic [1:0] reg_src,
    output logic       reg_we,
    output logic       alu_src,
    output logic [2:0] alu_op,
    output logic [2:0] state,
    output logic       instr_done,
    output logic       trap
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instr_count
`endif
);

    state_t       state_q;
    state_t       state_d;
    instr_class_t cls_q;
    instr_class_t dec_cls;
    logic         dec_legal;
    logic         pc_we_raw;
    logic         mem_we_raw;
    logic         reg_we_raw;
    logic         done_raw;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
            cls_q   <= CLS_NONE;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                cls_q <= dec_cls;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_we_raw    = 1'b0;
        mem_we_raw   = 1'b0;
        reg_we_raw   = 1'b0;
        done_raw     = 1'b0;
        br_sel       = 1'b0;
        pc_src       = PCSRC_RS;
        mem_addr_sel = MEMADDR_ALU;
        ir_sel       = 1'b0;
        reg_dst      = REGDST_R31;
        reg_src      = REGSRC_PC;
        alu_src      = ALUSRC_IMM;
        alu_op       = ALU_ADD;
        trap         = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_addr_sel = MEMADDR_PC;
                ir_sel       = 1'b1;
                pc_we_raw    = 1'b1;
                pc_src       = PCSRC_BRANCH;
                br_sel       = BRSEL_SEQ;
                state_d      = ST_DECODE;
            end

            ST_DECODE: begin
                state_d = dec_legal ? ST_EXEC : ST_TRAP;
            end

            ST_EXEC: begin
                alu_src = alu_src_of(cls_q);
                alu_op  = alu_cmd_of(cls_q);
                case (cls_q)
                    CLS_BNE: begin
                        pc_src    = PCSRC_BRANCH;
                        br_sel    = BRSEL_TAKEN;
                        pc_we_raw = ~zero;
                        done_raw  = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CLS_J: begin
                        pc_src    = PCSRC_JUMP;
                        pc_we_raw = 1'b1;
                        done_raw  = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    // JAL writes the return address while redirecting the PC.
                    CLS_JAL: begin
                        pc_src     = PCSRC_JUMP;
                        pc_we_raw  = 1'b1;
                        reg_dst    = REGDST_R31;
                        reg_src    = REGSRC_PC;
                        reg_we_raw = 1'b1;
                        done_raw   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    CLS_JR: begin
                        pc_src    = PCSRC_RS;
                        pc_we_raw = 1'b1;
                        done_raw  = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CLS_LW, CLS_SW: begin
                        state_d = ST_MEM;
                    end
                    CLS_ADDI, CLS_XORI, CLS_ADD, CLS_SUB, CLS_SLT: begin
                        state_d = ST_WB;
                    end
                    default: begin
                        state_d = ST_TRAP;
                    end
                endcase
            end

            ST_MEM: begin
                mem_addr_sel = MEMADDR_ALU;
                alu_op       = ALU_ADD;
                alu_src      = ALUSRC_IMM;
                case (cls_q)
                    CLS_SW: begin
                        mem_we_raw = 1'b1;
                        done_raw   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    CLS_LW: begin
                        ir_sel  = 1'b0;
                        state_d = ST_WB;
                    end
                    default: begin
                        state_d = ST_TRAP;
                    end
                endcase
            end

            ST_WB: begin
                alu_src = alu_src_of(cls_q);
                alu_op  = alu_cmd_of(cls_q);
                case (cls_q)
                    CLS_LW: begin
                        reg_dst    = REGDST_RT;
                        reg_src    = REGSRC_MEM;
                        reg_we_raw = 1'b1;
                        done_raw   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    CLS_ADDI, CLS_XORI: begin
                        reg_dst    = REGDST_RT;
                        reg_src    = REGSRC_ALU;
                        reg_we_raw = 1'b1;
                        done_raw   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    CLS_ADD, CLS_SUB, CLS_SLT: begin
                        reg_dst    = REGDST_RD;
                        reg_src    = REGSRC_ALU;
                        reg_we_raw = 1'b1;
                        done_raw   = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    default: begin
                        state_d = ST_TRAP;
                    end
                endcase
            end

            ST_TRAP: begin
                trap    = 1'b1;
                state_d = ST_TRAP;
            end

            default: begin
                state_d = ST_TRAP;
            end
        endcase
    end

    // A reset cycle aborts the instruction, so no write or completion escapes it.
    assign pc_we      = pc_we_raw & ~reset;
    assign mem_we     = mem_we_raw & ~reset;
    assign reg_we     = reg_we_raw & ~reset;
    assign instr_done = done_raw & ~reset;
    assign state      = state_q;

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= 32'd0;
            instr_count <= 32'd0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (instr_done) begin
                instr_count <= instr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and randomized
// instructions compared cycle by cycle against a per-instruction timing model.
module tb_multicycle_controller;

    localparam int K_LW   = 0;
    localparam int K_SW   = 1;
    localparam int K_J    = 2;
    localparam int K_JAL  = 3;
    localparam int K_BNE  = 4;
    localparam int K_ADDI = 5;
    localparam int K_XORI = 6;
    localparam int K_ADD  = 7;
    localparam int K_SUB  = 8;
    localparam int K_SLT  = 9;
    localparam int K_JR   = 10;
    localparam int K_ILL  = 11;

    typedef struct packed {
        logic       pc_we;
        logic       br_sel;
        logic [1:0] pc_src;
        logic       mem_addr_sel;
        logic       mem_we;
        logic       ir_sel;
        logic [1:0] reg_dst;
        logic [1:0] reg_src;
        logic       reg_we;
        logic       alu_src;
        logic [2:0] alu_op;
        logic [2:0] state;
        logic       instr_done;
        logic       trap;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pc_we;
    logic       br_sel;
    logic [1:0] pc_src;
    logic       mem_addr_sel;
    logic       mem_we;
    logic       ir_sel;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic       reg_we;
    logic       alu_src;
    logic [2:0] alu_op;
    logic [2:0] state;
    logic       instr_done;
    logic       trap;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
`endif

    obs_t observed;
    int   checks   = 0;
    int   failures = 0;

    multicycle_controller dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .pc_we        (pc_we),
        .br_sel       (br_sel),
        .pc_src       (pc_src),
        .mem_addr_sel (mem_addr_sel),
        .mem_we       (mem_we),
        .ir_sel       (ir_sel),
        .reg_dst      (reg_dst),
        .reg_src      (reg_src),
        .reg_we       (reg_we),
        .alu_src      (alu_src),
        .alu_op       (alu_op),
        .state        (state),
        .instr_done   (instr_done),
        .trap         (trap)
`ifdef MC_PERF_CNT_EN
        ,
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
`endif
    );

    always #5 clk = ~clk;

    assign observed = {pc_we, br_sel, pc_src, mem_addr_sel, mem_we, ir_sel,
                       reg_dst, reg_src, reg_we, alu_src, alu_op, state,
                       instr_done, trap};

    // Expected outputs for cycle 'step' of one instruction, written per
    // instruction from its documented timeline.
    function automatic void model_step(input int kind, input int step, input logic z,
                                       output obs_t e, output bit last);
        logic [2:0] op;
        logic       src;
        e    = '0;
        last = 1'b0;
        op   = 3'd0;
        src  = 1'b0;
        if (step == 0) begin
            e.state        = 3'd0;
            e.mem_addr_sel = 1'b1;
            e.ir_sel       = 1'b1;
            e.pc_we        = 1'b1;
            e.pc_src       = 2'd2;
            e.br_sel       = 1'b1;
        end else if (step == 1) begin
            e.state = 3'd1;
        end else if (kind == K_ILL) begin
            e.state = 3'd7;
            e.trap  = 1'b1;
        end else begin
            case (kind)
                K_J, K_JAL, K_JR: begin
                    e.state      = 3'd2;
                    e.pc_we      = 1'b1;
                    e.pc_src     = (kind == K_JR) ? 2'd0 : 2'd1;
                    e.reg_we     = (kind == K_JAL);
                    e.instr_done = 1'b1;
                    last         = 1'b1;
                end
                K_BNE: begin
                    e.state      = 3'd2;
                    e.alu_src    = 1'b1;
                    e.alu_op     = 3'd1;
                    e.pc_src     = 2'd2;
                    e.br_sel     = 1'b0;
                    e.pc_we      = ~z;
                    e.instr_done = 1'b1;
                    last         = 1'b1;
                end
                K_LW, K_SW: begin
                    if (step == 2) begin
                        e.state = 3'd2;
                    end else if (step == 3) begin
                        e.state = 3'd3;
                        if (kind == K_SW) begin
                            e.mem_we     = 1'b1;
                            e.instr_done = 1'b1;
                            last         = 1'b1;
                        end
                    end else begin
                        e.state      = 3'd4;
                        e.reg_we     = 1'b1;
                        e.reg_dst    = 2'd1;
                        e.reg_src    = 2'd1;
                        e.instr_done = 1'b1;
                        last         = 1'b1;
                    end
                end
                default: begin
                    case (kind)
                        K_XORI:  begin src = 1'b0; op = 3'd2; end
                        K_ADD:   begin src = 1'b1; op = 3'd0; end
                        K_SUB:   begin src = 1'b1; op = 3'd1; end
                        K_SLT:   begin src = 1'b1; op = 3'd3; end
                        default: begin src = 1'b0; op = 3'd0; end
                    endcase
                    e.alu_src = src;
                    e.alu_op  = op;
                    if (step == 2) begin
                        e.state = 3'd2;
                    end else begin
                        e.state      = 3'd4;
                        e.reg_we     = 1'b1;
                        e.reg_dst    = src ? 2'd2 : 2'd1;
                        e.reg_src    = 2'd2;
                        e.instr_done = 1'b1;
                        last         = 1'b1;
                    end
                end
            endcase
        end
    endfunction

    task automatic check_output(input string tag, input obs_t exp, input int kind, input int step);
        checks++;
        assert (observed === exp) else begin
            failures++;
            $error("[TB] FAIL %s step=%0d observed=%h expected=%h", tag, step, observed, exp);
        end
        checks++;
        assert (($countones({pc_we, mem_we, reg_we}) <= 1) ||
                (kind == K_JAL && step == 2 && {pc_we, mem_we, reg_we} === 3'b101)) else begin
            failures++;
            $error("[TB] FAIL %s_we_exclusive step=%0d observed=%b expected=at_most_one",
                   tag, step, {pc_we, mem_we, reg_we});
        end
    endtask

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    // Runs one instruction from its FETCH cycle; opcode/funct are only valid in
    // DECODE and scrambled elsewhere. abort_step >= 0 raises reset in that cycle.
    task automatic apply_stimulus(input string tag, input int kind, input logic [5:0] op,
                                  input logic [5:0] fn, input int zmode,
                                  input int trap_cycles, input int abort_step);
        obs_t e;
        bit   last;
        int   step;
        step = 0;
        last = 1'b0;
        while (!last && step < 16) begin
            if (step == 1) begin
                opcode = op;
                funct  = fn;
            end else begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            zero  = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            reset = (step == abort_step);
            @(negedge clk);
            model_step(kind, step, zero, e, last);
            if (kind == K_ILL && step >= 1 + trap_cycles) last = 1'b1;
            if (reset) begin
                e.pc_we      = 1'b0;
                e.mem_we     = 1'b0;
                e.reg_we     = 1'b0;
                e.instr_done = 1'b0;
                last         = 1'b1;
            end
            check_output(tag, e, kind, step);
            @(posedge clk);
            #1;
            step++;
        end
        reset = 1'b0;
    endtask

    task automatic do_reset();
        obs_t e;
        bit   last;
        reset  = 1'b1;
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        @(posedge clk);
        #1;
        @(negedge clk);
        model_step(K_ADD, 0, 1'b0, e, last);
        e.pc_we = 1'b0;
        check_output("reset_state", e, K_ADD, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic pick(input int idx, output int kind, output logic [5:0] op, output logic [5:0] fn);
        fn = 6'($urandom);
        case (idx)
            0:       begin kind = K_LW;   op = 6'b100011; end
            1:       begin kind = K_SW;   op = 6'b101011; end
            2:       begin kind = K_J;    op = 6'b000010; end
            3:       begin kind = K_JAL;  op = 6'b000011; end
            4:       begin kind = K_BNE;  op = 6'b000101; end
            5:       begin kind = K_ADDI; op = 6'b001000; end
            6:       begin kind = K_XORI; op = 6'b001110; end
            7:       begin kind = K_ADD;  op = 6'b000000; fn = 6'b100000; end
            8:       begin kind = K_SUB;  op = 6'b000000; fn = 6'b100010; end
            9:       begin kind = K_SLT;  op = 6'b000000; fn = 6'b101010; end
            default: begin kind = K_JR;   op = 6'b000000; fn = 6'b001000; end
        endcase
    endtask

    initial begin
        int         kind;
        logic [5:0] op;
        logic [5:0] fn;
        reset  = 1'b1;
        opcode = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;

        do_reset();
        apply_stimulus("add",     K_ADD,  6'b000000, 6'b100000, 0, 0, -1);
        apply_stimulus("lw",      K_LW,   6'b100011, 6'b010101, -1, 0, -1);
        apply_stimulus("sw",      K_SW,   6'b101011, 6'b000000, -1, 0, -1);
        apply_stimulus("bne_z1",  K_BNE,  6'b000101, 6'b000000, 1, 0, -1);
        apply_stimulus("bne_z0",  K_BNE,  6'b000101, 6'b000000, 0, 0, -1);
        apply_stimulus("jal",     K_JAL,  6'b000011, 6'b111111, -1, 0, -1);
        apply_stimulus("jr",      K_JR,   6'b000000, 6'b001000, -1, 0, -1);
        apply_stimulus("j",       K_J,    6'b000010, 6'b101010, -1, 0, -1);
        apply_stimulus("addi",    K_ADDI, 6'b001000, 6'b100010, -1, 0, -1);
        apply_stimulus("xori",    K_XORI, 6'b001110, 6'b000001, -1, 0, -1);
        apply_stimulus("sub",     K_SUB,  6'b000000, 6'b100010, -1, 0, -1);
        apply_stimulus("slt",     K_SLT,  6'b000000, 6'b101010, -1, 0, -1);

`ifdef MC_PERF_CNT_EN
        do_reset();
        check_value("cycle_count_reset", cycle_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus("perf_add", K_ADD, 6'b000000, 6'b100000, -1, 0, -1);
        end
        check_value("cycle_count", cycle_count, 32'd12);
        check_value("instr_count", instr_count, 32'd3);
`endif

        for (int i = 0; i < 150; i++) begin
            pick(int'($urandom_range(0, 10)), kind, op, fn);
            apply_stimulus("rand", kind, op, fn, -1, 0, -1);
        end

        apply_stimulus("lw_abort_mem", K_LW,  6'b100011, 6'b000000, -1, 0, 3);
        apply_stimulus("sw_abort_mem", K_SW,  6'b101011, 6'b000000, -1, 0, 3);
        apply_stimulus("add_abort_wb", K_ADD, 6'b000000, 6'b100000, -1, 0, 3);
        apply_stimulus("jal_abort",    K_JAL, 6'b000011, 6'b000000, -1, 0, 2);
        apply_stimulus("after_abort",  K_ADD, 6'b000000, 6'b100000, -1, 0, -1);

        apply_stimulus("trap_ff",   K_ILL, 6'b111111, 6'b000000, -1, 10, -1);
        do_reset();
        apply_stimulus("trap_addu", K_ILL, 6'b000000, 6'b100001, -1, 3, -1);
        do_reset();
        apply_stimulus("trap_beq",  K_ILL, 6'b000100, 6'b000000, -1, 3, -1);
        do_reset();
        apply_stimulus("post_trap", K_LW, 6'b100011, 6'b000000, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
